div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
- REQ-001 Parameters: none; the datapath is fixed at 32 bits.
- REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 data_operandA  input  32  signed dividend (two's complement); sampled only on a start edge.
- REQ-005 data_operandB  input  32  signed divisor (two's complement); sampled only on a start edge.
- REQ-006 ctrl_DIV  input  1  start pulse; a "start edge" is a rising clock edge at which ctrl_DIV=1.
- REQ-007 data_result  output  32  signed quotient, truncated toward zero.
- REQ-008 data_exception  output  1  error flag; valid whenever data_resultRDY=1.
- REQ-009 data_resultRDY  output  1  one-cycle completion strobe.

Function
- REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
- REQ-011 On a start edge with data_operandB != 0, the block SHALL:
  - latch |A|, |B|, sign(A) and sign(B);
  - clear the remainder register;
  - clear the 5-bit iteration counter;
  - enter RUN.
- REQ-012 In RUN, each cycle SHALL perform one restoring step:
  - shift {rem, quo} left by 1;
  - trial = rem - |B|, computed at 33-bit width;
  - if trial >= 0: rem = trial and quo[0] = 1; otherwise quo[0] = 0.
- REQ-013 After 32 steps (counter wrap from 31), the FSM SHALL enter DONE.
- REQ-014 In DONE:
  - data_result = quo, negated when sign(A) XOR sign(B);
  - data_resultRDY = 1 for exactly one cycle;
  - the FSM then returns to IDLE.
- REQ-015 Latency: with a start edge at edge k and a nonzero divisor, data_resultRDY SHALL be high in the cycle following edge k+33.
- REQ-016 data_result SHALL hold its value after DONE until the next DONE or reset.
- REQ-017 Divisor zero: a start edge with data_operandB=0 SHALL:
  - go directly to DONE;
  - assert data_resultRDY in the cycle following edge k+1, with data_exception=1 and data_result=0.
- REQ-018 Overflow: for A=0x80000000 and B=0xFFFFFFFF, the block SHALL take the normal latency, then assert data_exception=1 with data_result=0x80000000.
- REQ-019 data_exception SHALL be 0 in DONE for all other operand pairs, and SHALL be 0 whenever data_resultRDY=0.
- REQ-020 A start edge in RUN or DONE SHALL abort the current operation and restart with the newly sampled operands; no data_resultRDY pulse SHALL be emitted for the aborted operation.
- REQ-021 The magnitude of 0x80000000 SHALL be represented as unsigned 0x80000000 (no saturation in the absolute value).
- REQ-022 A zero dividend with a nonzero divisor SHALL yield data_result=0 and data_exception=0.

Reset
- REQ-023 reset=1 at a rising edge SHALL:
  - force the FSM to IDLE;
  - clear the counter, remainder and quotient registers;
  - drive data_result=0, data_exception=0 and data_resultRDY=0.
- REQ-024 reset SHALL take priority over ctrl_DIV at the same edge.
- REQ-025 Reset asserted mid-RUN SHALL discard the operation; no data_resultRDY pulse SHALL follow for it.

Configuration
- REQ-026 Macro DIV_REMAINDER_EN defined:
  - adds output port data_remainder (32 bits);
  - data_remainder = final rem, carrying the sign of the dividend;
  - data_remainder SHALL be valid and held with the same timing as data_result;
  - data_remainder SHALL be 0 on a divide-by-zero, on overflow and after reset.
- REQ-027 Macro DIV_REMAINDER_EN undefined: the data_remainder port and its sign-fix logic SHALL be absent; all other behaviour is identical.

Verification
- REQ-028 The bench SHALL cover these directed scenarios:
  - A=100, B=7, start at edge 0 -> data_resultRDY high after edge 33, result=14 (0x0000000E), exception=0, remainder=2 (if DIV_REMAINDER_EN).
  - A=-100, B=7 -> result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); A=100, B=-7 -> result=-14, remainder=2.
  - A=5, B=0 -> data_resultRDY after edge 1, exception=1, result=0; no further strobe.
  - A=0x80000000, B=0xFFFFFFFF -> exception=1, result=0x80000000 after edge 33.
  - Start A=100, B=7; re-start at edge 10 with A=9, B=3 -> single strobe after edge 43, result=3, exception=0.
  - Start A=100, B=7; reset at edge 20 -> all outputs 0 from edge 20 onward, no strobe; a fresh start after reset behaves as scenario 1.

Source files
------------

// File: rtl/div.sv
// 32-bit signed restoring divider: one quotient bit per clock, DONE strobe after 32 steps.
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module div (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
`ifdef DIV_REMAINDER_EN
    output logic [31:0] data_remainder,
`endif
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] abs_a, abs_b;
    logic [31:0] rem, quo;
    logic [4:0]  cnt;
    logic        sign_a, sign_b;
    logic        div_zero, overflow;
    logic        load, step, finish;
    logic [32:0] shifted, trial;

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // A start edge wins over normal sequencing from any state, which gives abort/restart.
    always_comb begin
        next_state = state;
        if (ctrl_DIV) begin
            next_state = (data_operandB == 32'd0) ? DONE : RUN;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                RUN:     if (cnt == 5'd31) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        load   = ctrl_DIV;
        step   = !ctrl_DIV && (state == RUN);
        finish = !ctrl_DIV && (state == DONE);
    end

    // The remainder always stays below |B| <= 2^31, so bit 32 of trial is a clean sign bit.
    always_comb begin
        shifted = {rem, quo[31]};
        trial   = shifted - {1'b0, abs_b};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            abs_a          <= 32'd0;
            abs_b          <= 32'd0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            div_zero       <= 1'b0;
            overflow       <= 1'b0;
            rem            <= 32'd0;
            quo            <= 32'd0;
            cnt            <= 5'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
            data_remainder <= 32'd0;
`endif
        end else begin
            data_resultRDY <= finish;
            data_exception <= finish && (div_zero || overflow);
            if (load) begin
                sign_a   <= data_operandA[31];
                sign_b   <= data_operandB[31];
                abs_a    <= data_operandA[31] ? -data_operandA : data_operandA;
                abs_b    <= data_operandB[31] ? -data_operandB : data_operandB;
                quo      <= data_operandA[31] ? -data_operandA : data_operandA;
                rem      <= 32'd0;
                cnt      <= 5'd0;
                div_zero <= (data_operandB == 32'd0);
                overflow <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            end else if (step) begin
                if (!trial[32]) begin
                    rem <= trial[31:0];
                    quo <= {quo[30:0], 1'b1};
                end else begin
                    rem <= shifted[31:0];
                    quo <= {quo[30:0], 1'b0};
                end
                cnt <= cnt + 5'd1;
            end else if (finish) begin
                if (div_zero)
                    data_result <= 32'd0;
                else
                    data_result <= (sign_a ^ sign_b) ? -quo : quo;
`ifdef DIV_REMAINDER_EN
                if (div_zero || overflow)
                    data_remainder <= 32'd0;
                else
                    data_remainder <= sign_a ? -rem : rem;
`endif
            end
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the div block; remainder checks follow DIV_REMAINDER_EN.
module tb_div;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [31:0] rem_obs;

    int vectors;
    int miscompares;

    div dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
`ifdef DIV_REMAINDER_EN
        .data_remainder (rem_obs),
`endif
        .data_resultRDY (data_resultRDY)
    );

`ifndef DIV_REMAINDER_EN
    assign rem_obs = 32'd0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one start edge; returns 1 ns after that edge with ctrl_DIV released.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
    endtask

    // Runs 60 edges, reporting the first strobe edge, its outputs and the number of strobes.
    task automatic wait_ready(output int edge_no, output int strobes,
                              output logic [31:0] res, output logic exc, output logic [31:0] rm);
        edge_no = -1;
        strobes = 0;
        res     = 32'hDEAD_BEEF;
        exc     = 1'bx;
        rm      = 32'hDEAD_BEEF;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                strobes++;
                if (edge_no < 0) begin
                    edge_no = n;
                    res     = data_result;
                    exc     = data_exception;
                    rm      = rem_obs;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ctrl_DIV = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        repeat (3) @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        reset    = 1'b0;
        vectors++;
        if (data_result !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_result got %h want %h", data_result, 32'd0);
        end
        vectors++;
        if (data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got exc=%b rdy=%b want 0 0", data_exception, data_resultRDY);
        end
        vectors++;
        if (rem_obs !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_remainder got %h want 0", rem_obs);
        end
    endtask

    // Reset and start together: reset must win, so no strobe may follow.
    task automatic test_reset_priority();
        int e, s;
        logic [31:0] r, m;
        logic x;
        reset = 1'b1;
        start_op(32'd100, 32'd7);
        reset = 1'b0;
        wait_ready(e, s, r, x, m);
        vectors++;
        if (s !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_priority strobes got %0d want 0", s);
        end
    endtask

    task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b,
                             input int exp_edge, input logic [31:0] exp_res,
                             input logic exp_exc, input logic [31:0] exp_rem);
        int e, s;
        logic [31:0] r, m;
        logic x;
        start_op(a, b);
        wait_ready(e, s, r, x, m);
        vectors++;
        if (e !== exp_edge) begin
            miscompares++;
            $display("[TB] FAIL %s latency got %0d want %0d", name, e, exp_edge);
        end
        vectors++;
        if (s !== 1) begin
            miscompares++;
            $display("[TB] FAIL %s strobes got %0d want 1", name, s);
        end
        vectors++;
        if (r !== exp_res) begin
            miscompares++;
            $display("[TB] FAIL %s result got %h want %h", name, r, exp_res);
        end
        vectors++;
        if (x !== exp_exc) begin
            miscompares++;
            $display("[TB] FAIL %s exception got %b want %b", name, x, exp_exc);
        end
        vectors++;
        if (data_result !== exp_res || data_exception !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s hold got res=%h exc=%b want res=%h exc=0",
                     name, data_result, data_exception, exp_res);
        end
`ifdef DIV_REMAINDER_EN
        vectors++;
        if (m !== exp_rem) begin
            miscompares++;
            $display("[TB] FAIL %s remainder got %h want %h", name, m, exp_rem);
        end
`endif
    endtask

    task automatic test_basic();
        check_div("pos_pos", 32'd100, 32'd7, 33, 32'h0000_000E, 1'b0, 32'd2);
    endtask

    task automatic test_signs();
        check_div("neg_pos", 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 1'b0, 32'hFFFF_FFFE);
        check_div("pos_neg", 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 1'b0, 32'd2);
        check_div("neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'h0000_000E, 1'b0, 32'hFFFF_FFFE);
    endtask

    task automatic test_div_zero();
        check_div("div_zero", 32'd5, 32'd0, 1, 32'd0, 1'b1, 32'd0);
    endtask

    task automatic test_overflow();
        check_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1, 32'd0);
    endtask

    task automatic test_boundaries();
        check_div("zero_dividend", 32'd0, 32'd5, 33, 32'd0, 1'b0, 32'd0);
        check_div("min_by_two", 32'h8000_0000, 32'd2, 33, 32'hC000_0000, 1'b0, 32'd0);
        check_div("max_by_min", 32'h7FFF_FFFF, 32'h8000_0000, 33, 32'd0, 1'b0, 32'h7FFF_FFFF);
    endtask

    // Re-start at edge 10 must suppress the first strobe and finish at edge 43.
    task automatic test_restart();
        int first, strobes;
        logic [31:0] res;
        first   = -1;
        strobes = 0;
        res     = 32'hDEAD_BEEF;
        start_op(32'd100, 32'd7);
        for (int e = 1; e <= 70; e++) begin
            if (e == 10) begin
                data_operandA = 32'd9;
                data_operandB = 32'd3;
                ctrl_DIV      = 1'b1;
            end
            @(posedge clock);
            #1;
            ctrl_DIV = 1'b0;
            if (data_resultRDY === 1'b1) begin
                strobes++;
                if (first < 0) begin
                    first = e;
                    res   = data_result;
                end
            end
        end
        vectors++;
        if (strobes !== 1 || first !== 43) begin
            miscompares++;
            $display("[TB] FAIL restart_strobe got %0d strobes first=%0d want 1 at 43", strobes, first);
        end
        vectors++;
        if (res !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL restart_result got %h want %h", res, 32'd3);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        start_op(32'd100, 32'd7);
        for (int e = 1; e <= 60; e++) begin
            if (e == 20) reset = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b0;
            if (e >= 20 && (data_result !== 32'd0 || data_exception !== 1'b0 ||
                            data_resultRDY !== 1'b0 || rem_obs !== 32'd0))
                bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid nonzero output cycles got %0d want 0", bad);
        end
        check_div("after_reset", 32'd100, 32'd7, 33, 32'h0000_000E, 1'b0, 32'd2);
    endtask

    task automatic test_back_to_back();
        check_div("b2b_first", 32'd9, 32'd3, 33, 32'd3, 1'b0, 32'd0);
        check_div("b2b_second", 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        @(negedge clock);
        test_reset();
        test_reset_priority();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_boundaries();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
